// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//   Turns a simple valid/ready request from a core into one APB transfer
//   (IDLE -> SETUP -> ACCESS) and returns a single-cycle completion pulse.
//   An ACCESS phase that waits too long on M_PREADY is aborted and reported
//   through resp_err.
//
// Parameters
//   BUS_WIDTH  : address width
//   DATA_WIDTH : data width
//   TIMEOUT    : maximum ACCESS wait cycles, 0 disables the timeout
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only while IDLE)
//   req_write/addr/wdata  : request payload, captured on handshake
//   resp_valid            : one-cycle completion pulse
//   resp_rdata/resp_err   : completion payload, held until the next pulse
//   M_P*                  : APB master port towards the interconnect
// ---------------------------------------------------------------------------
module apb_master_bridge #(
   parameter int BUS_WIDTH  = 16,
   parameter int DATA_WIDTH = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic [BUS_WIDTH-1:0]  req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic [BUS_WIDTH-1:0]  M_PADDR,
   output logic                  M_PWRITE,
   output logic                  M_PSELx,
   output logic                  M_PENABLE,
   output logic [DATA_WIDTH-1:0] M_PWDATA,
   input  logic [DATA_WIDTH-1:0] M_PRDATA,
   input  logic                  M_PREADY
);

   // Counter wide enough to hold TIMEOUT itself (it saturates there).
   localparam int CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] TO_SAT  = CW'(TIMEOUT);
   // Value held during the last permitted ACCESS cycle.
   localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t                state_q,      state_d;
   logic                  req_ready_q,  req_ready_d;
   logic                  resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
   logic                  resp_err_q,   resp_err_d;
   logic [BUS_WIDTH-1:0]  paddr_q,      paddr_d;
   logic                  pwrite_q,     pwrite_d;
   logic                  psel_q,       psel_d;
   logic                  penable_q,    penable_d;
   logic [DATA_WIDTH-1:0] pwdata_q,     pwdata_d;
   logic [CW-1:0]         cnt_q,        cnt_d;

   logic handshake;
   logic timed_out;

   assign handshake = req_valid && req_ready_q;
   assign timed_out = (TIMEOUT > 0) && (cnt_q == TO_LAST);

   always_comb begin
      state_d      = state_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      paddr_d      = paddr_q;
      pwrite_d     = pwrite_q;
      pwdata_d     = pwdata_q;
      cnt_d        = cnt_q;

      case (state_q)
         IDLE: begin
            if (handshake) begin
               paddr_d  = req_addr;
               pwrite_d = req_write;
               pwdata_d = req_wdata;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            cnt_d   = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (!M_PREADY && cnt_q != TO_SAT) begin
               cnt_d = cnt_q + 1'b1;
            end
            // A ready slave wins over a timeout landing in the same cycle.
            if (M_PREADY) begin
               state_d      = IDLE;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = pwrite_q ? '0 : M_PRDATA;
            end else if (timed_out) begin
               state_d      = IDLE;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
               resp_rdata_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Bus controls are registered from the next state so they line up
      // with the state they describe.
      req_ready_d = (state_d == IDLE);
      psel_d      = (state_d != IDLE);
      penable_d   = (state_d == ACCESS);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         paddr_q      <= '0;
         pwrite_q     <= 1'b0;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         pwdata_q     <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         paddr_q      <= paddr_d;
         pwrite_q     <= pwrite_d;
         psel_q       <= psel_d;
         penable_q    <= penable_d;
         pwdata_q     <= pwdata_d;
         cnt_q        <= cnt_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign M_PADDR    = paddr_q;
   assign M_PWRITE   = pwrite_q;
   assign M_PSELx    = psel_q;
   assign M_PENABLE  = penable_q;
   assign M_PWDATA   = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge (TIMEOUT=8). Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_apb_master_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_write;
   logic [15:0] req_addr, req_wdata;
   logic        req_ready, resp_valid, resp_err;
   logic [15:0] resp_rdata;
   logic [15:0] M_PADDR, M_PWDATA, M_PRDATA;
   logic        M_PWRITE, M_PSELx, M_PENABLE, M_PREADY;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   apb_master_bridge #(.BUS_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(8)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx),
      .M_PENABLE(M_PENABLE), .M_PWDATA(M_PWDATA),
      .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic next_cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          wait_n;     // ACCESS cycles with PREADY low before ready
      logic [15:0] prdata;
      logic [15:0] exp_rdata;
      logic        exp_err;
      int          exp_pen;    // cycles PENABLE is high
      int          exp_lat;    // handshake edge -> resp_valid cycle
   } vec_t;

   vec_t tbl [6];

   // One full transfer from the table, with req_* scrambled after handshake.
   task automatic run_vec(input int idx, input vec_t v);
      int k;
      int cyc;
      bit got;
      chk($sformatf("v%0d ready_before", idx), req_ready, 1);
      req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
      M_PREADY  = 1'b0; M_PRDATA = v.prdata;
      next_cyc();
      cyc = 1;
      req_valid = 1'b0; req_addr = ~v.addr; req_wdata = ~v.wdata; req_write = ~v.wr;
      chk($sformatf("v%0d setup_psel", idx), {M_PSELx, M_PENABLE}, 2'b10);
      chk($sformatf("v%0d setup_paddr", idx), M_PADDR, v.addr);
      chk($sformatf("v%0d setup_pwdata", idx), M_PWDATA, v.wdata);
      chk($sformatf("v%0d setup_pwrite", idx), M_PWRITE, v.wr);
      chk($sformatf("v%0d setup_ready", idx), req_ready, 0);
      M_PREADY = 1'b1;   // must be ignored in SETUP
      k = 0; got = 0;
      for (int n = 0; n < 40; n++) begin
         next_cyc();
         cyc++;
         req_addr = 16'($urandom); req_wdata = 16'($urandom);
         if (resp_valid) begin got = 1; break; end
         if (M_PENABLE && M_PSELx) begin
            k++;
            if (M_PADDR !== v.addr || M_PWDATA !== v.wdata)
               chk($sformatf("v%0d access_hold", idx), {M_PADDR, M_PWDATA}, {v.addr, v.wdata});
            M_PREADY = (k > v.wait_n);
         end else begin
            chk($sformatf("v%0d access_phase", idx), {M_PSELx, M_PENABLE}, 2'b11);
            break;
         end
      end
      chk($sformatf("v%0d resp_seen", idx), got, 1);
      chk($sformatf("v%0d pen_cycles", idx), k, v.exp_pen);
      chk($sformatf("v%0d latency", idx), cyc, v.exp_lat);
      chk($sformatf("v%0d rdata", idx), resp_rdata, v.exp_rdata);
      chk($sformatf("v%0d err", idx), resp_err, v.exp_err);
      chk($sformatf("v%0d resp_bus_idle", idx), {M_PSELx, M_PENABLE, req_ready}, 3'b001);
      M_PREADY = 1'b0;
      next_cyc();
      chk($sformatf("v%0d pulse_once", idx), resp_valid, 0);
      chk($sformatf("v%0d rdata_hold", idx), {resp_rdata, resp_err}, {v.exp_rdata, v.exp_err});
      chk($sformatf("v%0d idle_after", idx), M_PSELx, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0] psel_seq, rv_seq;
      //          wr    addr      wdata     wt  prdata    exp_rd    err pen lat
      tbl[0] = '{1'b1, 16'h0010, 16'hBEEF, 0,  16'hAAAA, 16'h0000, 1'b0, 1, 3};
      tbl[1] = '{1'b0, 16'h0200, 16'h0000, 4,  16'h1234, 16'h1234, 1'b0, 5, 7};
      tbl[2] = '{1'b0, 16'h0300, 16'h0000, 99, 16'h5555, 16'h0000, 1'b1, 8, 10};
      tbl[3] = '{1'b0, 16'h0400, 16'h0000, 7,  16'h4321, 16'h4321, 1'b0, 8, 10};
      tbl[4] = '{1'b1, 16'hFFFF, 16'h0001, 2,  16'h7777, 16'h0000, 1'b0, 3, 5};
      tbl[5] = '{1'b0, 16'h0000, 16'h0000, 0,  16'hFFFF, 16'hFFFF, 1'b0, 1, 3};

      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
      req_addr = '0; req_wdata = '0; M_PRDATA = '0; M_PREADY = 1'b0;
      #23;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp", {resp_valid, resp_err}, 2'b00);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_bus_ctl", {M_PSELx, M_PENABLE, M_PWRITE}, 3'b000);
      chk("rst_paddr", M_PADDR, 0);
      chk("rst_pwdata", M_PWDATA, 0);
      @(negedge clk);
      reset = 1'b0;
      next_cyc();

      for (int i = 0; i < 6; i++) run_vec(i, tbl[i]);

      // Back-to-back: req_valid held high, slave always ready.
      M_PREADY = 1'b1; M_PRDATA = 16'h0BAD;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0A00; req_wdata = 16'h1111;
      psel_seq = '0; rv_seq = '0;
      next_cyc();                                   // +1 SETUP of first
      req_addr = 16'h0B00; req_wdata = 16'h2222;
      chk("b2b_first_addr", M_PADDR, 16'h0A00);
      next_cyc();                                   // +2 ACCESS
      next_cyc();                                   // +3 resp, second handshake edge follows
      chk("b2b_resp1", {resp_valid, req_ready, M_PSELx}, 3'b110);
      next_cyc();                                   // +4 SETUP of second
      req_valid = 1'b0;
      chk("b2b_second_setup", {M_PSELx, M_PENABLE}, 2'b10);
      chk("b2b_second_addr", M_PADDR, 16'h0B00);
      chk("b2b_second_wdata", M_PWDATA, 16'h2222);
      next_cyc();                                   // +5 ACCESS
      next_cyc();                                   // +6 resp
      chk("b2b_resp2", {resp_valid, resp_err, M_PSELx}, 3'b100);
      next_cyc();
      chk("b2b_no_third", {M_PSELx, resp_valid}, 2'b00);

      // Reset asserted during ACCESS.
      M_PREADY = 1'b0; M_PRDATA = 16'h9999;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0C00;
      next_cyc();
      req_valid = 1'b0;
      next_cyc();
      chk("rst_mid_in_access", {M_PSELx, M_PENABLE}, 2'b11);
      #2 reset = 1'b1;
      #1;
      chk("rst_mid_async_bus", {M_PSELx, M_PENABLE}, 2'b00);
      chk("rst_mid_ready", {req_ready, resp_valid}, 2'b10);
      @(negedge clk);
      reset = 1'b0; M_PREADY = 1'b1;
      for (int n = 0; n < 4; n++) begin
         next_cyc();
         if (resp_valid !== 1'b0 || M_PSELx !== 1'b0)
            chk("rst_mid_no_resp", {resp_valid, M_PSELx}, 2'b00);
      end
      chk("rst_mid_final", {resp_valid, req_ready, M_PSELx}, 3'b010);
      M_PREADY = 1'b0;

      // Transfer still works after the aborted one.
      run_vec(6, tbl[1]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameter BUS_WIDTH, default 16, address width.
REQ-002 Parameter DATA_WIDTH, default 16, data width.
REQ-003 Parameter TIMEOUT, default 255, maximum ACCESS wait cycles; 0 disables timeout.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  core requests a transfer.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  BUS_WIDTH  transfer address.
REQ-009 req_wdata  input  DATA_WIDTH  write data.
REQ-010 req_ready  output  1  bridge can accept a request this cycle.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  DATA_WIDTH  read data; valid with resp_valid.
REQ-013 resp_err  output  1  transfer aborted by timeout; valid with resp_valid.
REQ-014 M_PADDR  output  BUS_WIDTH  APB address to interconnect slave port.
REQ-015 M_PWRITE  output  1  APB direction.
REQ-016 M_PSELx  output  1  APB select.
REQ-017 M_PENABLE  output  1  APB enable.
REQ-018 M_PWDATA  output  DATA_WIDTH  APB write data.
REQ-019 M_PRDATA  input  DATA_WIDTH  APB read data from interconnect.
REQ-020 M_PREADY  input  1  APB ready from interconnect.

Function
REQ-021 FSM states IDLE, SETUP, ACCESS; all outputs driven from registers.
REQ-022 req_ready SHALL be 1 only in IDLE; handshake = req_valid && req_ready.
REQ-023 On handshake, addr/write/wdata captured; next state SETUP; M_PADDR, M_PWRITE, M_PWDATA hold captured values until return to IDLE.
REQ-024 SETUP: M_PSELx=1, M_PENABLE=0, exactly one cycle; then ACCESS.
REQ-025 ACCESS: M_PSELx=1, M_PENABLE=1; held until M_PREADY=1 or timeout.
REQ-026 M_PREADY sampled only in ACCESS; ignored in IDLE and SETUP.
REQ-027 On M_PREADY=1 in ACCESS: next cycle state IDLE, M_PSELx=M_PENABLE=0, resp_valid=1, resp_err=0, resp_rdata=M_PRDATA for reads, 0 for writes.
REQ-028 Wait counter cleared on ACCESS entry, increments each ACCESS cycle with M_PREADY=0, saturates at TIMEOUT.
REQ-029 If TIMEOUT>0 and counter reaches TIMEOUT with M_PREADY=0: next cycle IDLE, PSEL/PENABLE=0, resp_valid=1, resp_err=1, resp_rdata=0.
REQ-030 M_PREADY=1 in the same cycle the counter reaches TIMEOUT: completes normally, resp_err=0.
REQ-031 resp_valid is high exactly one cycle per accepted request; req_ready is high in that same cycle, so back-to-back requests are allowed (min 3 cycles per transfer).
REQ-032 resp_rdata and resp_err hold their values until the next resp_valid.
REQ-033 Minimum latency handshake -> resp_valid = 3 cycles (handshake, SETUP, ACCESS with M_PREADY=1, resp cycle at +3).
REQ-034 req_* changes after handshake SHALL NOT affect the in-flight transfer.

Reset
REQ-035 reset=1 forces IDLE immediately, regardless of clk.
REQ-036 Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, M_PADDR=0, M_PWRITE=0, M_PSELx=0, M_PENABLE=0, M_PWDATA=0, counter=0.
REQ-037 Reset mid-transfer drops M_PSELx/M_PENABLE asynchronously; no resp_valid for the aborted request.

Verification
REQ-038 Write addr 0x0010 data 0xBEEF, M_PREADY=1 in first ACCESS cycle -> SETUP at +1, ACCESS at +2, resp_valid at +3, resp_err=0.
REQ-039 Read addr 0x0200, M_PREADY low 4 ACCESS cycles then high with M_PRDATA=0x1234 -> PENABLE high 5 cycles, resp_rdata=0x1234.
REQ-040 TIMEOUT=8, M_PREADY held 0 -> resp_valid with resp_err=1, resp_rdata=0 after 8 ACCESS cycles; PSEL low next cycle.
REQ-041 req_valid held high for two requests -> second handshake in resp_valid cycle of first; PSEL low for exactly one cycle between transfers.
REQ-042 reset pulsed during ACCESS -> M_PSELx=M_PENABLE=0 before next clk edge, no resp_valid, req_ready=1.
REQ-043 req_addr/req_wdata toggled during SETUP/ACCESS -> M_PADDR/M_PWDATA stable at captured values.
